// File: rtl/sys_defs.sv
// Shared rename-stage definitions used by the map table, retirement map table,
// free list and ROB.
package sys_defs;

    localparam int unsigned NUM_ARCH_REGS  = 32;
    localparam int unsigned AREG_IDX_WIDTH = $clog2(NUM_ARCH_REGS);
    localparam int unsigned PREG_IDX_WIDTH = 6;
    localparam int unsigned SCALAR         = 2;

    typedef struct packed {
        logic [PREG_IDX_WIDTH-1:0] tag;
        logic                      ready;
    } MAP_TABLE_ENTRY;

    typedef struct packed {
        logic                      rename_en;
        logic [AREG_IDX_WIDTH-1:0] src1_areg;
        logic [AREG_IDX_WIDTH-1:0] src2_areg;
        logic [AREG_IDX_WIDTH-1:0] dest_areg;
        logic [PREG_IDX_WIDTH-1:0] new_tag;
    } RENAME_INPACKET;

    typedef struct packed {
        logic [PREG_IDX_WIDTH-1:0] src1_tag;
        logic                      src1_ready;
        logic [PREG_IDX_WIDTH-1:0] src2_tag;
        logic                      src2_ready;
        logic [PREG_IDX_WIDTH-1:0] old_tag;
    } RENAME_OUTPACKET;

    typedef struct packed {
        logic                      valid;
        logic [PREG_IDX_WIDTH-1:0] tag;
    } CDB_PACKET;

endpackage

// File: rtl/map_table_entry.sv
// One architectural register mapping: physical tag plus ready bit.
// Local priority: reset > rollback > rename > CDB wakeup.
module map_table_entry #(
    parameter int unsigned SCALAR         = sys_defs::SCALAR,
    parameter int unsigned PREG_IDX_WIDTH = sys_defs::PREG_IDX_WIDTH,
    parameter int unsigned RESET_TAG      = 0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 rollback,
    input  logic [PREG_IDX_WIDTH-1:0]            rb_tag,
    input  logic                                 rename_we,
    input  logic [PREG_IDX_WIDTH-1:0]            rename_tag,
    input  logic [SCALAR-1:0]                    cdb_valid,
    input  logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0] cdb_tag,
    output logic [PREG_IDX_WIDTH-1:0]            tag,
    output logic                                 ready
);

    logic cdb_hit;

    always_comb begin
        cdb_hit = 1'b0;
        for (int k = 0; k < SCALAR; k++) begin
            if (cdb_valid[k] && (cdb_tag[k] == tag)) begin
                cdb_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag   <= PREG_IDX_WIDTH'(RESET_TAG);
            ready <= 1'b1;
        end else if (rollback) begin
            tag   <= rb_tag;
            ready <= 1'b1;
        end else if (rename_we) begin
            tag   <= rename_tag;
            ready <= 1'b0;
        end else if (cdb_hit) begin
            ready <= 1'b1;
        end
    end

endmodule

// File: rtl/map_table.sv
// Speculative front-end register alias table for the rename bundle.
// Optional MAP_TABLE_CDB_BYPASS_EN: sources woken by a same-cycle CDB broadcast read as ready.
module map_table #(
    parameter int unsigned SCALAR         = sys_defs::SCALAR,
    parameter int unsigned NUM_ENTRIES    = sys_defs::NUM_ARCH_REGS,
    parameter int unsigned AREG_IDX_WIDTH = $clog2(NUM_ENTRIES),
    parameter int unsigned PREG_IDX_WIDTH = sys_defs::PREG_IDX_WIDTH
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [SCALAR-1:0]                         rename_en,
    input  logic [SCALAR-1:0][AREG_IDX_WIDTH-1:0]     src1_areg,
    input  logic [SCALAR-1:0][AREG_IDX_WIDTH-1:0]     src2_areg,
    input  logic [SCALAR-1:0][AREG_IDX_WIDTH-1:0]     dest_areg,
    input  logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]     new_tag,
    output logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]     src1_tag,
    output logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]     src2_tag,
    output logic [SCALAR-1:0]                         src1_ready,
    output logic [SCALAR-1:0]                         src2_ready,
    output logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]     old_tag,
    input  logic [SCALAR-1:0]                         cdb_valid,
    input  logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]     cdb_tag,
    input  logic                                      rollback,
    input  logic [NUM_ENTRIES-1:0][PREG_IDX_WIDTH-1:0] rrat_copy_tag
);

    logic [PREG_IDX_WIDTH-1:0] map_tag   [NUM_ENTRIES];
    logic                      map_ready [NUM_ENTRIES];

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        logic                      we;
        logic [PREG_IDX_WIDTH-1:0] wtag;

        // Later slots overwrite earlier ones, so the youngest rename of a register wins.
        always_comb begin
            we   = 1'b0;
            wtag = '0;
            for (int s = 0; s < SCALAR; s++) begin
                if (rename_en[s] && (dest_areg[s] != '0) &&
                    (dest_areg[s] == AREG_IDX_WIDTH'(i))) begin
                    we   = 1'b1;
                    wtag = new_tag[s];
                end
            end
        end

        map_table_entry #(
            .SCALAR        (SCALAR),
            .PREG_IDX_WIDTH(PREG_IDX_WIDTH),
            .RESET_TAG     (i)
        ) u_entry (
            .clock     (clock),
            .reset     (reset),
            .rollback  (rollback),
            .rb_tag    ((i == 0) ? '0 : rrat_copy_tag[i]),
            .rename_we (we),
            .rename_tag(wtag),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .tag       (map_tag[i]),
            .ready     (map_ready[i])
        );
    end

`ifdef MAP_TABLE_CDB_BYPASS_EN
    function automatic logic cdb_match(input logic [PREG_IDX_WIDTH-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < SCALAR; k++) begin
            if (cdb_valid[k] && (cdb_tag[k] == t)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction
`endif

    always_comb begin
        for (int j = 0; j < SCALAR; j++) begin
            src1_tag[j]   = map_tag[src1_areg[j]];
            src1_ready[j] = map_ready[src1_areg[j]];
            src2_tag[j]   = map_tag[src2_areg[j]];
            src2_ready[j] = map_ready[src2_areg[j]];
            old_tag[j]    = map_tag[dest_areg[j]];
            // Intra-bundle forwarding from older slots; the youngest older writer wins.
            for (int k = 0; k < j; k++) begin
                if (rename_en[k] && (dest_areg[k] != '0)) begin
                    if (src1_areg[j] == dest_areg[k]) begin
                        src1_tag[j]   = new_tag[k];
                        src1_ready[j] = 1'b0;
                    end
                    if (src2_areg[j] == dest_areg[k]) begin
                        src2_tag[j]   = new_tag[k];
                        src2_ready[j] = 1'b0;
                    end
                    if (dest_areg[j] == dest_areg[k]) begin
                        old_tag[j] = new_tag[k];
                    end
                end
            end
`ifdef MAP_TABLE_CDB_BYPASS_EN
            if (cdb_match(src1_tag[j])) begin
                src1_ready[j] = 1'b1;
            end
            if (cdb_match(src2_tag[j])) begin
                src2_ready[j] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_map_table.sv
// Scoreboard bench for map_table: stimulus queues expected outputs, a negedge monitor checks them.
module tb_map_table;

    localparam int SC = 2;
    localparam int NE = 32;
    localparam int AW = 5;
    localparam int PW = 6;

    localparam int K_S1T = 0;
    localparam int K_S1R = 1;
    localparam int K_S2T = 2;
    localparam int K_S2R = 3;
    localparam int K_OLD = 4;

`ifdef MAP_TABLE_CDB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic                      clock;
    logic                      reset;
    logic [SC-1:0]             rename_en;
    logic [SC-1:0][AW-1:0]     src1_areg, src2_areg, dest_areg;
    logic [SC-1:0][PW-1:0]     new_tag;
    logic [SC-1:0][PW-1:0]     src1_tag, src2_tag, old_tag;
    logic [SC-1:0]             src1_ready, src2_ready;
    logic [SC-1:0]             cdb_valid;
    logic [SC-1:0][PW-1:0]     cdb_tag;
    logic                      rollback;
    logic [NE-1:0][PW-1:0]     rrat_copy_tag;

    map_table dut (
        .clock        (clock),
        .reset        (reset),
        .rename_en    (rename_en),
        .src1_areg    (src1_areg),
        .src2_areg    (src2_areg),
        .dest_areg    (dest_areg),
        .new_tag      (new_tag),
        .src1_tag     (src1_tag),
        .src2_tag     (src2_tag),
        .src1_ready   (src1_ready),
        .src2_ready   (src2_ready),
        .old_tag      (old_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .rollback     (rollback),
        .rrat_copy_tag(rrat_copy_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    kind;
        int    slot;
        int    exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic expect_out(input string name, input int kind, input int slot, input int v);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.slot = slot;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    function automatic int actual(input int kind, input int slot);
        case (kind)
            K_S1T:   return int'(src1_tag[slot]);
            K_S1R:   return int'(src1_ready[slot]);
            K_S2T:   return int'(src2_tag[slot]);
            K_S2R:   return int'(src2_ready[slot]);
            default: return int'(old_tag[slot]);
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t e;
        int   act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = actual(e.kind, e.slot);
            n_checks++;
            if (act != e.exp) begin
                n_errors++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        rename_en = '0;
        cdb_valid = '0;
        rollback  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        rename_en = '0;
        src1_areg = '0;
        src2_areg = '0;
        dest_areg = '0;
        new_tag   = '0;
        cdb_valid = '0;
        cdb_tag   = '0;
        rollback  = 1'b0;
        for (int i = 0; i < NE; i++) rrat_copy_tag[i] = PW'(i + 32);
        tick();
        tick();
        reset = 1'b0;

        // Reset state reads as identity mapping, all ready.
        src1_areg[0] = 5'd3;  src1_areg[1] = 5'd7;
        src2_areg[0] = 5'd0;  src2_areg[1] = 5'd31;
        dest_areg[0] = 5'd5;  dest_areg[1] = 5'd9;
        expect_out("rst_src1_tag0", K_S1T, 0, 3);
        expect_out("rst_src1_tag1", K_S1T, 1, 7);
        expect_out("rst_src1_rdy0", K_S1R, 0, 1);
        expect_out("rst_src1_rdy1", K_S1R, 1, 1);
        expect_out("rst_src2_tag0", K_S2T, 0, 0);
        expect_out("rst_src2_tag1", K_S2T, 1, 31);
        expect_out("rst_old_tag0",  K_OLD, 0, 5);
        expect_out("rst_old_tag1",  K_OLD, 1, 9);
        tick();

        // Rename x5 -> 40.
        rename_en = 2'b01; dest_areg[0] = 5'd5; new_tag[0] = 6'd40;
        expect_out("ren5_old_tag0", K_OLD, 0, 5);
        tick();

        src1_areg[0] = 5'd5;
        expect_out("rd5_tag",     K_S1T, 0, 40);
        expect_out("rd5_rdy",     K_S1R, 0, 0);
        expect_out("rd5_old_tag", K_OLD, 0, 40);
        tick();

        // Bundle: slot0 x4->41, slot1 reads x4 and renames x4->42.
        rename_en = 2'b11;
        dest_areg[0] = 5'd4; new_tag[0] = 6'd41;
        dest_areg[1] = 5'd4; new_tag[1] = 6'd42;
        src2_areg[1] = 5'd4; src1_areg[1] = 5'd5;
        expect_out("byp_src2_tag1", K_S2T, 1, 41);
        expect_out("byp_src2_rdy1", K_S2R, 1, 0);
        expect_out("byp_old_tag1",  K_OLD, 1, 41);
        expect_out("byp_old_tag0",  K_OLD, 0, 4);
        expect_out("byp_src1_tag1", K_S1T, 1, 40);
        tick();

        // x4 now 42; CDB wakes tag 40 on port 1.
        src1_areg[0] = 5'd4; src1_areg[1] = 5'd5;
        cdb_valid = 2'b10; cdb_tag[1] = 6'd40;
        expect_out("same_dest_tag", K_S1T, 0, 42);
        expect_out("same_dest_rdy", K_S1R, 0, 0);
        expect_out("cdb_same_tag",  K_S1T, 1, 40);
        expect_out("cdb_same_rdy",  K_S1R, 1, BYP);
        tick();

        // x5 now ready; rename x5->43 races CDB tag 40.
        src1_areg[0] = 5'd5; src1_areg[1] = 5'd5;
        rename_en = 2'b01; dest_areg[0] = 5'd5; new_tag[0] = 6'd43;
        cdb_valid = 2'b01; cdb_tag[0] = 6'd40;
        expect_out("cdb_next_tag",  K_S1T, 0, 40);
        expect_out("cdb_next_rdy",  K_S1R, 0, 1);
        expect_out("race_old_tag0", K_OLD, 0, 40);
        expect_out("race_byp_tag1", K_S1T, 1, 43);
        expect_out("race_byp_rdy1", K_S1R, 1, 0);
        tick();

        rename_en = 2'b01; dest_areg[0] = 5'd6; new_tag[0] = 6'd45;
        expect_out("race_tag", K_S1T, 0, 43);
        expect_out("race_rdy", K_S1R, 0, 0);
        expect_out("ren6_old", K_OLD, 0, 6);
        tick();

        src2_areg[0] = 5'd6;
        cdb_valid = 2'b01; cdb_tag[0] = 6'd45;
        expect_out("cdb_byp_tag", K_S2T, 0, 45);
        expect_out("cdb_byp_rdy", K_S2R, 0, BYP);
        tick();

        // Reg 6 ready next cycle; rollback discards the x3 rename.
        expect_out("cdb6_next_rdy", K_S2R, 0, 1);
        rename_en = 2'b01; dest_areg[0] = 5'd3; new_tag[0] = 6'd44;
        rollback = 1'b1;
        tick();

        src1_areg[0] = 5'd3; src1_areg[1] = 5'd5;
        src2_areg[0] = 5'd0; src2_areg[1] = 5'd31;
        dest_areg[0] = 5'd6; dest_areg[1] = 5'd9;
        expect_out("rb_tag3",  K_S1T, 0, 35);
        expect_out("rb_rdy3",  K_S1R, 0, 1);
        expect_out("rb_tag5",  K_S1T, 1, 37);
        expect_out("rb_rdy5",  K_S1R, 1, 1);
        expect_out("rb_tag0",  K_S2T, 0, 0);
        expect_out("rb_rdy0",  K_S2R, 0, 1);
        expect_out("rb_tag31", K_S2T, 1, 63);
        expect_out("rb_old6",  K_OLD, 0, 38);
        tick();

        // Rename to x0: no write, no bypass.
        rename_en = 2'b01; dest_areg[0] = 5'd0; new_tag[0] = 6'd50;
        src1_areg[1] = 5'd0;
        expect_out("x0_old_tag",  K_OLD, 0, 0);
        expect_out("x0_nobyp_tag", K_S1T, 1, 0);
        expect_out("x0_nobyp_rdy", K_S1R, 1, 1);
        tick();

        src1_areg[0] = 5'd0;
        rename_en = 2'b11;
        dest_areg[0] = 5'd7; new_tag[0] = 6'd20;
        dest_areg[1] = 5'd7; new_tag[1] = 6'd21;
        expect_out("x0_stays_tag", K_S1T, 0, 0);
        expect_out("x0_stays_rdy", K_S1R, 0, 1);
        expect_out("dup_old_tag0", K_OLD, 0, 39);
        expect_out("dup_old_tag1", K_OLD, 1, 20);
        tick();

        src1_areg[0] = 5'd7;
        expect_out("dup_win_tag", K_S1T, 0, 21);
        expect_out("dup_win_rdy", K_S1R, 0, 0);
        tick();

        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
